mp_trace_checker: RTL and testbench
===================================

# mp_trace_checker

Passive monitor for the lab microprogram sequencer. Samples the sequencer's 4-bit state code every clock, checks each step against the fixed microprogram graph (S_0 through S_8, then ENDSTATE), and reports which branch was taken, how many times the S_4/S_5 loop repeated, completion, and the first illegal step. It sits beside the sequencer in lab benches and on-board debug and drives nothing back into it.

## Interface
- LOOP_W, 8, width of the loop counter; saturates at all-ones.
- clk  in  1  rising-edge clock, same clock as the sequencer.
- reset  in  1  synchronous, active-low reset.
- valid  in  1  state_in is meaningful this cycle; when low, the sample is ignored and all outputs hold.
- state_in  in  4  sequencer state code: 0–8 = S_0..S_8, 9 = ENDSTATE, 10–15 = illegal.
- done  out  1  ENDSTATE has been reached via a legal path.
- path  out  2  branch taken: 00 none yet, 01 short branch (S_1→S_2), 10 loop branch (S_1→S_4).
- loops  out  LOOP_W  count of S_5→S_4 transitions in the current run.
- error  out  1  sticky flag; a violation has been detected.
- err_code  out  3  000 none, 001 illegal transition, 010 out-of-range code, 011 first sample not S_0.

## Operation
- The checker FSM has four states: IDLE, TRACK, DONE, FAIL. A register `prev` holds the last accepted code.
- **IDLE**
  - valid & state_in = S_0 → TRACK, prev = S_0.
  - Code 10–15 → FAIL, err 010.
  - Any other code → FAIL, err 011.
- **TRACK**
  - Each valid sample is checked against the legal successors of prev:
    - S_0→S_1
    - S_1→S_2 or S_4
    - S_2→S_3
    - S_3→S_7
    - S_4→S_5
    - S_5→S_4 or S_6
    - S_6→S_8
    - S_7→S_8
    - S_8→ENDSTATE
  - Legal sample → prev = state_in.
  - S_1→S_2 sets path = 01. S_1→S_4 sets path = 10.
  - S_5→S_4 increments loops, saturating.
  - Sample ENDSTATE → DONE.
  - Sample S_0 from any code → restart: prev = S_0, path = 00, loops = 0, stay in TRACK. This models a sequencer reset.
  - Code 10–15 → FAIL, err 010.
  - Any other successor → FAIL, err 001.
- **DONE**
  - ENDSTATE repeating is legal: hold.
  - S_0 → restart into TRACK with done cleared.
  - Anything else → FAIL with the matching err code.
- **FAIL**
  - Absorbing: every input is ignored.
  - error, err_code, path and loops freeze at their values at detection.
  - Exit only via reset.
- Only the first violation is recorded.

## Timing
- All outputs are registered. The effect of a sample accepted on edge N is visible after edge N.
- Latency is one cycle from sample to the update of done, error, path and loops.
- On reset low at an edge, the next cycle has:
  - FSM = IDLE, prev = S_0
  - done = 0, path = 00, loops = 0, error = 0, err_code = 000
- Reset applies mid-run, overrides valid, and overrides FAIL.
- valid low for any number of cycles: no state change. The next valid sample is checked against the held prev.
- The loop counter at all-ones plus a further S_5→S_4 stays at all-ones and raises no error.
- done and error are never both 1.

## Structure
- Shared package mp_pkg holds:
  - State-code constants S_0..S_8 and ENDSTATE (4-bit), shared with the sequencer.
  - Checker FSM encoding: IDLE, TRACK, DONE, FAIL.
  - Error-code constants.
- One combinational sub-module, mp_next_legal:
  - Inputs prev and cur.
  - Outputs legal, plus is_branch_short, is_branch_loop and is_loop_back decode flags.
- The top-level holds the FSM, prev, counters and output registers.

## Test plan
- Reset, then stream 0,1,2,3,7,8,9,9 with valid = 1 → path = 01, loops = 0, done = 1 after the first 9 is sampled, error = 0.
- Stream 0,1,4,5,4,5,4,5,6,8,9 → path = 10, loops = 2, done = 1.
- With LOOP_W = 2, stream 0,1 then (4,5) ×6, then 6,8,9 → loops saturates at 3, done = 1, no error.
- Stream 0,1,2,7 → error = 1, err_code = 001 one cycle after the 7. Then send 0,1 → outputs unchanged. Then assert reset → all outputs clear.
- Start with 3 → err 011. Separately, stream 0,1,12 → err 010.
- Stream 0,1,4, then valid = 0 for 5 cycles, then 5,6,8,9 → done = 1. Also stream 0,1,4,5, then 0,1,2,3,7,8,9 (sequencer reset mid-run) → path = 01, loops = 0, done = 1.

Source files
------------

// File: rtl/mp_pkg.sv
// mp_pkg: shared definitions for the lab microprogram sequencer and its
// trace checker.
//   - State codes S_0..S_8 and ENDSTATE (4-bit), as the sequencer emits them.
//   - Checker FSM encoding.
//   - Error codes reported on err_code.
//   - Helper that flags codes above ENDSTATE.
package mp_pkg;

  localparam logic [3:0] S_0      = 4'd0;
  localparam logic [3:0] S_1      = 4'd1;
  localparam logic [3:0] S_2      = 4'd2;
  localparam logic [3:0] S_3      = 4'd3;
  localparam logic [3:0] S_4      = 4'd4;
  localparam logic [3:0] S_5      = 4'd5;
  localparam logic [3:0] S_6      = 4'd6;
  localparam logic [3:0] S_7      = 4'd7;
  localparam logic [3:0] S_8      = 4'd8;
  localparam logic [3:0] ENDSTATE = 4'd9;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_TRACK = 2'd1,
    CHK_DONE  = 2'd2,
    CHK_FAIL  = 2'd3
  } chk_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_RANGE   = 3'd2;
  localparam logic [2:0] ERR_START   = 3'd3;

  localparam logic [1:0] PATH_NONE  = 2'b00;
  localparam logic [1:0] PATH_SHORT = 2'b01;
  localparam logic [1:0] PATH_LOOP  = 2'b10;

  // Codes 10..15 do not name any sequencer state.
  function automatic logic is_out_of_range(input logic [3:0] code);
    return (code > ENDSTATE);
  endfunction

endpackage

// File: rtl/mp_next_legal.sv
// mp_next_legal: combinational decode of one step of the microprogram graph.
// Ports:
//   prev            in  4  last accepted state code
//   cur             in  4  newly sampled state code
//   legal           out 1  cur is a graph successor of prev
//   is_branch_short out 1  step is S_1 -> S_2
//   is_branch_loop  out 1  step is S_1 -> S_4
//   is_loop_back    out 1  step is S_5 -> S_4
// Restart to S_0 is not a graph edge; the caller handles it separately.
module mp_next_legal
  import mp_pkg::*;
(
  input  logic [3:0] prev,
  input  logic [3:0] cur,
  output logic       legal,
  output logic       is_branch_short,
  output logic       is_branch_loop,
  output logic       is_loop_back
);

  // Successor table of the fixed microprogram graph.
  always_comb begin
    legal = 1'b0;
    case (prev)
      S_0:     legal = (cur == S_1);
      S_1:     legal = (cur == S_2) || (cur == S_4);
      S_2:     legal = (cur == S_3);
      S_3:     legal = (cur == S_7);
      S_4:     legal = (cur == S_5);
      S_5:     legal = (cur == S_4) || (cur == S_6);
      S_6:     legal = (cur == S_8);
      S_7:     legal = (cur == S_8);
      S_8:     legal = (cur == ENDSTATE);
      default: legal = 1'b0;
    endcase
  end

  assign is_branch_short = (prev == S_1) && (cur == S_2);
  assign is_branch_loop  = (prev == S_1) && (cur == S_4);
  assign is_loop_back    = (prev == S_5) && (cur == S_4);

endmodule

// File: rtl/mp_trace_checker.sv
// mp_trace_checker: passive monitor of the microprogram sequencer state code.
// Ports:
//   clk       in  1       rising-edge clock shared with the sequencer
//   reset     in  1       synchronous active-low reset
//   valid     in  1       state_in is meaningful this cycle
//   state_in  in  4       sequencer state code
//   done      out 1       ENDSTATE reached via a legal path
//   path      out 2       00 none, 01 short branch, 10 loop branch
//   loops     out LOOP_W  S_5->S_4 count, saturating
//   error     out 1       sticky violation flag
//   err_code  out 3       first violation cause
// All outputs are registers; a sample accepted on edge N shows after edge N.
module mp_trace_checker #(
  parameter int LOOP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [3:0]        state_in,
  output logic              done,
  output logic [1:0]        path,
  output logic [LOOP_W-1:0] loops,
  output logic              error,
  output logic [2:0]        err_code
);
  import mp_pkg::*;

  chk_state_e        state_r, state_s;
  logic [3:0]        prev_r, prev_s;
  logic              done_r, done_s;
  logic [1:0]        path_r, path_s;
  logic [LOOP_W-1:0] loops_r, loops_s;
  logic              error_r, error_s;
  logic [2:0]        err_code_r, err_code_s;

  logic legal_s, branch_short_s, branch_loop_s, loop_back_s;

  mp_next_legal u_next_legal (
    .prev            (prev_r),
    .cur             (state_in),
    .legal           (legal_s),
    .is_branch_short (branch_short_s),
    .is_branch_loop  (branch_loop_s),
    .is_loop_back    (loop_back_s)
  );

  // Next-state and next-output computation for the checker FSM.
  always_comb begin
    state_s    = state_r;
    prev_s     = prev_r;
    done_s     = done_r;
    path_s     = path_r;
    loops_s    = loops_r;
    error_s    = error_r;
    err_code_s = err_code_r;

    if (valid && (state_r != CHK_FAIL)) begin
      if (state_in == S_0) begin
        // S_0 from any live state means the sequencer restarted.
        state_s = CHK_TRACK;
        prev_s  = S_0;
        done_s  = 1'b0;
        path_s  = PATH_NONE;
        loops_s = '0;
      end else if (is_out_of_range(state_in)) begin
        state_s    = CHK_FAIL;
        done_s     = 1'b0;
        error_s    = 1'b1;
        err_code_s = ERR_RANGE;
      end else begin
        case (state_r)
          CHK_IDLE: begin
            state_s    = CHK_FAIL;
            error_s    = 1'b1;
            err_code_s = ERR_START;
          end
          CHK_TRACK: begin
            if (legal_s) begin
              prev_s = state_in;
              if (branch_short_s) begin
                path_s = PATH_SHORT;
              end else if (branch_loop_s) begin
                path_s = PATH_LOOP;
              end else begin
                path_s = path_r;
              end
              if (loop_back_s && !(&loops_r)) begin
                loops_s = loops_r + {{(LOOP_W-1){1'b0}}, 1'b1};
              end else begin
                loops_s = loops_r;
              end
              if (state_in == ENDSTATE) begin
                state_s = CHK_DONE;
                done_s  = 1'b1;
              end else begin
                state_s = CHK_TRACK;
              end
            end else begin
              state_s    = CHK_FAIL;
              error_s    = 1'b1;
              err_code_s = ERR_ILLEGAL;
            end
          end
          CHK_DONE: begin
            if (state_in == ENDSTATE) begin
              state_s = CHK_DONE;
            end else begin
              // done and error must never be set together.
              state_s    = CHK_FAIL;
              done_s     = 1'b0;
              error_s    = 1'b1;
              err_code_s = ERR_ILLEGAL;
            end
          end
          default: begin
            state_s = state_r;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= CHK_IDLE;
      prev_r     <= S_0;
      done_r     <= 1'b0;
      path_r     <= PATH_NONE;
      loops_r    <= '0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      state_r    <= state_s;
      prev_r     <= prev_s;
      done_r     <= done_s;
      path_r     <= path_s;
      loops_r    <= loops_s;
      error_r    <= error_s;
      err_code_r <= err_code_s;
    end
  end

  assign done     = done_r;
  assign path     = path_r;
  assign loops    = loops_r;
  assign error    = error_r;
  assign err_code = err_code_r;

endmodule

// File: tb/tb_mp_trace_checker.sv
// Directed bench for mp_trace_checker: a default-width instance and a
// LOOP_W = 2 instance share the same stimulus.
module tb_mp_trace_checker;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [3:0] state_in;

  logic       done_a, error_a;
  logic [1:0] path_a;
  logic [7:0] loops_a;
  logic [2:0] err_code_a;

  logic       done_b, error_b;
  logic [1:0] path_b;
  logic [1:0] loops_b;
  logic [2:0] err_code_b;

  int checks   = 0;
  int failures = 0;

  mp_trace_checker #(.LOOP_W(8)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .state_in(state_in),
    .done(done_a), .path(path_a), .loops(loops_a),
    .error(error_a), .err_code(err_code_a)
  );

  mp_trace_checker #(.LOOP_W(2)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .state_in(state_in),
    .done(done_b), .path(path_b), .loops(loops_b),
    .error(error_b), .err_code(err_code_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] code);
    @(negedge clk);
    valid    = 1'b1;
    state_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid    = 1'b0;
      state_in = 4'd15;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b1;
    state_in = 4'd3;
    @(posedge clk);
    #1;
    reset = 1'b1;
    valid = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_done"},  32'(done_a),     32'd0);
    check({tag, "_path"},  32'(path_a),     32'd0);
    check({tag, "_loops"}, 32'(loops_a),    32'd0);
    check({tag, "_error"}, 32'(error_a),    32'd0);
    check({tag, "_code"},  32'(err_code_a), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    valid    = 1'b0;
    state_in = 4'd0;

    // Reset state
    do_reset();
    check_clear("rst");

    // Short branch: 0,1,2,3,7,8,9,9
    step(4'd0); step(4'd1); step(4'd2);
    check("short_path_after2", 32'(path_a), 32'd1);
    step(4'd3); step(4'd7); step(4'd8);
    check("short_done_before9", 32'(done_a), 32'd0);
    step(4'd9);
    check("short_done", 32'(done_a), 32'd1);
    check("short_path", 32'(path_a), 32'd1);
    check("short_loops", 32'(loops_a), 32'd0);
    check("short_error", 32'(error_a), 32'd0);
    step(4'd9);
    check("short_done_hold", 32'(done_a), 32'd1);
    check("short_err_hold", 32'(error_a), 32'd0);

    // Restart from DONE, then loop branch: 0,1,4,5,4,5,4,5,6,8,9
    step(4'd0);
    check("restart_done_clr", 32'(done_a), 32'd0);
    check("restart_path_clr", 32'(path_a), 32'd0);
    step(4'd1);
    check("loop_path_after1", 32'(path_a), 32'd0);
    step(4'd4);
    check("loop_path_after4", 32'(path_a), 32'd2);
    step(4'd5); step(4'd4);
    check("loop_count1", 32'(loops_a), 32'd1);
    step(4'd5); step(4'd4); step(4'd5); step(4'd6); step(4'd8); step(4'd9);
    check("loop_path", 32'(path_a), 32'd2);
    check("loop_loops", 32'(loops_a), 32'd2);
    check("loop_done", 32'(done_a), 32'd1);

    // Saturation: 0,1,(4,5)x6,6,8,9 -> five loop-backs
    do_reset();
    step(4'd0); step(4'd1);
    for (int i = 0; i < 6; i++) begin
      step(4'd4); step(4'd5);
    end
    step(4'd6); step(4'd8); step(4'd9);
    check("sat_loops_w2", 32'(loops_b), 32'd3);
    check("sat_done_w2", 32'(done_b), 32'd1);
    check("sat_error_w2", 32'(error_b), 32'd0);
    check("sat_loops_w8", 32'(loops_a), 32'd5);

    // Illegal transition 2->7, then FAIL absorbs 0,1, then reset clears
    do_reset();
    step(4'd0); step(4'd1); step(4'd2);
    check("ill_error_before", 32'(error_a), 32'd0);
    step(4'd7);
    check("ill_error", 32'(error_a), 32'd1);
    check("ill_code", 32'(err_code_a), 32'd1);
    check("ill_done", 32'(done_a), 32'd0);
    check("ill_path", 32'(path_a), 32'd1);
    step(4'd0); step(4'd1);
    check("fail_hold_error", 32'(error_a), 32'd1);
    check("fail_hold_code", 32'(err_code_a), 32'd1);
    check("fail_hold_path", 32'(path_a), 32'd1);
    do_reset();
    check_clear("fail_rst");

    // First sample not S_0
    step(4'd3);
    check("start_error", 32'(error_a), 32'd1);
    check("start_code", 32'(err_code_a), 32'd3);

    // Out-of-range code in TRACK
    do_reset();
    step(4'd0); step(4'd1); step(4'd12);
    check("range_error", 32'(error_a), 32'd1);
    check("range_code", 32'(err_code_a), 32'd2);
    check("range_path", 32'(path_a), 32'd0);

    // Out-of-range as first sample
    do_reset();
    step(4'd10);
    check("range_idle_code", 32'(err_code_a), 32'd2);

    // valid gaps: 0,1,4, idle x5, 5,6,8,9
    do_reset();
    step(4'd0); step(4'd1); step(4'd4);
    idle(5);
    check("gap_path", 32'(path_a), 32'd2);
    check("gap_error", 32'(error_a), 32'd0);
    check("gap_done", 32'(done_a), 32'd0);
    step(4'd5); step(4'd6); step(4'd8); step(4'd9);
    check("gap_done_end", 32'(done_a), 32'd1);
    check("gap_error_end", 32'(error_a), 32'd0);

    // Mid-run sequencer reset: 0,1,4,5,4, then 0,1,2,3,7,8,9
    do_reset();
    step(4'd0); step(4'd1); step(4'd4); step(4'd5); step(4'd4);
    check("mid_loops_pre", 32'(loops_a), 32'd1);
    step(4'd0);
    check("mid_path_clr", 32'(path_a), 32'd0);
    check("mid_loops_clr", 32'(loops_a), 32'd0);
    step(4'd1); step(4'd2); step(4'd3); step(4'd7); step(4'd8); step(4'd9);
    check("mid_path", 32'(path_a), 32'd1);
    check("mid_loops", 32'(loops_a), 32'd0);
    check("mid_done", 32'(done_a), 32'd1);

    // DONE followed by a non-ENDSTATE, non-S_0 code is illegal
    step(4'd3);
    check("done_bad_error", 32'(error_a), 32'd1);
    check("done_bad_code", 32'(err_code_a), 32'd1);
    check("done_bad_done", 32'(done_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
